// File: rtl/dmem_byte_ram.sv
// Word-organised data memory with byte-lane writes, zero-latency reads, a post-reset zero-fill sweep and out-of-range flagging.
// Optional load/store access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module dmem_byte_ram #(
    parameter int unsigned DEPTH         = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [3:0]  byte_mask_i,
    input  logic [31:0] wdata_i,
    input  logic        rd_en_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        addr_err_o,
    output logic [31:0] ld_cnt_o,
    output logic [31:0] st_cnt_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    // state_q is the observable FSM state for checkers bound to this block.
    typedef enum logic {INIT, READY} state_t;
    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? INIT : READY;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_idx_q, init_idx_d;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     off;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            ready;
    logic            wr_en;
    logic            rd_hit;
    logic            bad_access;
    logic            addr_err_q;

    assign off        = addr_i - BASE_ADDR;
    assign idx        = AW'(off >> 2);
    assign in_range   = (addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
    // Gating with rst_n keeps the array untouched while reset is held, even when no sweep is configured.
    assign ready      = rst_n && (state_q == READY);
    assign wr_en      = ready && (byte_mask_i != 4'b0000) && in_range;
    assign rd_hit     = ready && rd_en_i && in_range;
    assign bad_access = ready && (rd_en_i || (byte_mask_i != 4'b0000)) && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        busy_o     = 1'b0;
        case (state_q)
            INIT: begin
                busy_o     = 1'b1;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                busy_o = 1'b0;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state_q == INIT)) begin
            mem[init_idx_q] <= '0;
        end else if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (byte_mask_i[n]) begin
                    mem[idx][8*n +: 8] <= wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Combinational read returns the pre-write word when a write hits the same index this cycle.
    assign rdata_o = rd_hit ? mem[idx] : 32'h0000_0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= bad_access;
        end
    end

    assign addr_err_o = addr_err_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt_q;
    logic [31:0] st_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (rd_hit) begin
                ld_cnt_q <= ld_cnt_q + 32'd1;
            end
            if (wr_en) begin
                st_cnt_q <= st_cnt_q + 32'd1;
            end
        end
    end

    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;
`else
    assign ld_cnt_o = 32'h0000_0000;
    assign st_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dmem_byte_ram.sv
// Randomised scoreboard bench for dmem_byte_ram (DEPTH=16, BASE_ADDR=0, zero-fill on reset).
// Expected responses come from an array model; a negedge monitor pops and compares them.
module tb_dmem_byte_ram;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_ACCESS_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  byte_mask_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rd_en_i = 1'b0;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        addr_err_o;
    logic [31:0] ld_cnt_o;
    logic [31:0] st_cnt_o;

    dmem_byte_ram #(
        .DEPTH         (DEPTH),
        .BASE_ADDR     (BASE),
        .INIT_ON_RESET (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (addr_i),
        .byte_mask_i (byte_mask_i),
        .wdata_i     (wdata_i),
        .rd_en_i     (rd_en_i),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .addr_err_o  (addr_err_o),
        .ld_cnt_o    (ld_cnt_o),
        .st_cnt_o    (st_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    logic        exp_busy_q[$];

    // Reference model: word array, cycles of sweep left, pending error, access counts.
    logic [31:0] model_mem[DEPTH];
    int          init_left;
    logic        err_pending;
    int unsigned ld_model;
    int unsigned st_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && (o < 32'(4 * DEPTH));
    endfunction

    // One access cycle: called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic [31:0] a, input logic [3:0] m, input logic [31:0] w, input logic r);
        bit ready;
        bit inr;
        int unsigned idx;
        addr_i      = a;
        byte_mask_i = m;
        wdata_i     = w;
        rd_en_i     = r;
        ready = (init_left == 0);
        inr   = in_rng(a);
        idx   = ((a - BASE) >> 2) % DEPTH;
        exp_q.push_back((ready && r && inr) ? model_mem[idx] : 32'h0);
        exp_err_q.push_back(err_pending);
        exp_busy_q.push_back(!ready);
        if (ready && inr && m != 4'b0) begin
            for (int n = 0; n < 4; n++)
                if (m[n]) model_mem[idx][8*n +: 8] = w[8*n +: 8];
            st_model++;
        end
        if (ready && inr && r) ld_model++;
        err_pending = ready && (r || m != 4'b0) && !inr;
        if (!ready) init_left--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        addr_i      = 32'h0;
        rd_en_i     = 1'b1;
        byte_mask_i = 4'hF;
        wdata_i     = $urandom;
        #1;
        check("reset_rdata", rdata_o, 32'h0);
        check("reset_busy", {31'b0, busy_o}, 32'h1);
        check("reset_err", {31'b0, addr_err_o}, 32'h0);
        check("reset_ld_cnt", ld_cnt_o, 32'h0);
        check("reset_st_cnt", st_cnt_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        rd_en_i     = 1'b0;
        byte_mask_i = 4'h0;
        init_left   = DEPTH;
        err_pending = 1'b0;
        ld_model    = 0;
        st_model    = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ld_cnt"}, ld_cnt_o, CNT_ON ? ld_model : 32'h0);
        check({tag, "_st_cnt"}, st_cnt_o, CNT_ON ? st_model : 32'h0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("rdata", rdata_o, exp_q.pop_front());
            check("addr_err", {31'b0, addr_err_o}, {31'b0, exp_err_q.pop_front()});
            check("busy", {31'b0, busy_o}, {31'b0, exp_busy_q.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        int          sel;

        do_reset();
        for (int i = 0; i < DEPTH; i++) drive((i % 2) ? 32'h3C : 32'h0, 4'h0, 32'h0, 1'b1);
        drive(32'h0, 4'h0, 32'h0, 1'b1);
        drive(32'h3C, 4'h0, 32'h0, 1'b1);

        drive(32'h8, 4'hF, 32'hDEADBEEF, 1'b0);
        drive(32'h8, 4'h0, 32'h0, 1'b1);
        drive(32'hA, 4'b0100, 32'h00AB0000, 1'b0);
        drive(32'h8, 4'h0, 32'h0, 1'b1);

        drive(32'hC, 4'hF, 32'h11111111, 1'b0);
        drive(32'hC, 4'hF, 32'h22222222, 1'b1);
        drive(32'hC, 4'h0, 32'h0, 1'b1);

        drive(32'h40, 4'hF, 32'hCAFEF00D, 1'b0);
        drive(32'h0, 4'h0, 32'h0, 1'b1);
        drive(32'h40, 4'h0, 32'h0, 1'b1);
        drive(32'hFFFF_FFFC, 4'h3, 32'h12345678, 1'b1);
        drive(32'h3C, 4'hF, 32'h0BADF00D, 1'b1);
        drive(32'h3C, 4'h0, 32'h0, 1'b1);
        check_counters("directed");

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'($urandom_range(0, 63));
            else if (sel == 8) a = 32'($urandom_range(64, 255));
            else               a = $urandom;
            m = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            drive(a, m, $urandom, 1'($urandom_range(0, 1)));
        end
        check_counters("random");

        do_reset();
        repeat (5) drive(32'h0, 4'h0, 32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(32'(4 * i), 4'hF, $urandom, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(32'(4 * i), 4'h0, 32'h0, 1'b1);
        check_counters("midinit");

        do_reset();
        repeat (DEPTH) drive(32'h0, 4'h0, 32'h0, 1'b0);
        drive(32'h4, 4'h0, 32'h0, 1'b1);
        drive(32'h8, 4'h0, 32'h0, 1'b1);
        drive(32'h10, 4'hF, 32'h5A5A5A5A, 1'b0);
        drive(32'h14, 4'b1000, 32'hA5000000, 1'b0);
        drive(32'h10, 4'h0, 32'h0, 1'b1);
        drive(32'h80, 4'h0, 32'h0, 1'b1);
        drive(32'h0, 4'h0, 32'h0, 1'b0);
        check("exact_ld_cnt", ld_cnt_o, CNT_ON ? 32'd3 : 32'd0);
        check("exact_st_cnt", st_cnt_o, CNT_ON ? 32'd2 : 32'd0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_byte_ram.md
Name: dmem_byte_ram

Overview:
- Word-organised data memory sitting directly downstream of the MEM pipeline stage.
- Consumes the stage's word-aligned address, byte write mask and lane-aligned write data.
- Returns the full 32-bit word, which the MEM stage slices and sign-extends for loads.
- Zero-fills itself after reset through an init state machine, and flags out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the init sweep.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- addr_i  input  32  byte address; bits [1:0] ignored
- byte_mask_i  input  4  per-lane write enable, bit n = byte lane n ([8n+7:8n]); non-zero = write
- wdata_i  input  32  lane-aligned write data
- rd_en_i  input  1  read request
- rdata_o  output  32  read word
- busy_o  output  1  high while init sweep is in progress
- addr_err_o  output  1  one-cycle pulse after an out-of-range access
- ld_cnt_o  output  32  load counter (optional feature)
- st_cnt_o  output  32  store counter (optional feature)

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - state = INIT if INIT_ON_RESET = 1, else READY.
  - init_idx = 0.
  - addr_err_o = 0; ld_cnt_o = st_cnt_o = 0.
  - rdata_o = 0 while rst_n is low.
- Address decode:
  - off = addr_i - BASE_ADDR (32-bit).
  - in_range = (addr_i >= BASE_ADDR) && (off < 4*DEPTH).
  - idx = off[log2(DEPTH)+1:2].
- FSM, two states:
  - INIT: each posedge writes mem[init_idx] = 0 and increments init_idx. After the write of DEPTH-1, the state moves to READY on that same edge. busy_o = 1. The sweep takes exactly DEPTH cycles after reset release.
  - READY: busy_o = 0. Stays in READY until reset.
- Reset asserted mid-sweep: state returns to INIT and init_idx to 0; the full DEPTH-cycle sweep restarts.
- INIT_ON_RESET = 0: reset does not touch array contents; READY immediately after release.
- Writes (READY only):
  - At posedge, if byte_mask_i != 0 and in_range, each lane n with mask bit set gets mem[idx][8n+7:8n] = wdata_i[8n+7:8n].
  - Other lanes are unchanged.
- Reads (READY only):
  - rdata_o is combinational: rdata_o = mem[idx] when rd_en_i && in_range, else 0.
  - Zero added latency: data is valid in the same cycle as the address.
- Same-cycle read and write to the same idx: rdata_o shows the pre-write word; the new word is visible from the next cycle.
- Access during INIT: writes are dropped, rdata_o = 0, no error, counters do not change.
- Out-of-range access: (rd_en_i || byte_mask_i != 0) && !in_range in READY.
  - Write dropped; rdata_o = 0.
  - addr_err_o = 1 for exactly the following cycle; back-to-back bad accesses keep it high.
- Read and write may be asserted in the same cycle; both are honoured.

Optional Feature:
- Macro DMEM_ACCESS_CNT_EN.
- Defined:
  - ld_cnt_o increments by 1 per posedge where READY && rd_en_i && in_range.
  - st_cnt_o increments by 1 per posedge where READY && byte_mask_i != 0 && in_range.
  - A cycle with both increments both counters.
  - 32-bit, wrap at 2^32; reset to 0; not affected by the init sweep.
- Undefined: counter logic is absent; ld_cnt_o and st_cnt_o are tied to 0. The port list is unchanged.

Test Plan:
- Init sweep: DEPTH=16, INIT_ON_RESET=1, release rst_n -> busy_o = 1 for exactly 16 cycles, then 0; read of 0x0 and 0x3C returns 0x00000000.
- Word write/read: write 0x8, mask 4'b1111, wdata 0xDEADBEEF -> next cycle, rd_en_i at 0x8 returns 0xDEADBEEF; store at byte offset 0xA (byte mask 4'b0100, wdata 0x00AB0000) -> read of 0x8 returns 0xDEABBEEF.
- Same-cycle RAW: 0xC holds 0x11111111; write 0x22222222 with simultaneous read of 0xC -> rdata_o = 0x11111111 that cycle, 0x22222222 the next.
- Out of range: DEPTH=16, BASE_ADDR=0, write 0x40 mask 4'b1111 -> addr_err_o = 1 for one cycle, rdata_o = 0, a read of 0x0 shows no change.
- Reset mid-init: assert rst_n low at init_idx = 5, release -> busy_o high for a full 16 cycles again; writes issued during busy are dropped and read back as 0.
- Counters (macro defined): 3 in-range loads, 2 in-range stores, 1 out-of-range load -> ld_cnt_o = 3, st_cnt_o = 2; macro undefined -> both outputs read 0.
